// File: rtl/ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, RV32I opcodes
// and the datapath select constants.
package ctrl_fsm_pkg;

    typedef enum logic [1:0] {
        S_FLUSH   = 2'd0,
        S_EXEC    = 2'd1,
        S_MEM     = 2'd2,
        S_LOAD_WB = 2'd3
    } state_t;

    // opcode field [6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [2:0] IMM_I       = 3'd0;
    localparam logic [2:0] IMM_S       = 3'd1;
    localparam logic [2:0] IMM_B       = 3'd2;
    localparam logic [2:0] IMM_U       = 3'd3;
    localparam logic [2:0] IMM_J       = 3'd4;
    localparam logic [2:0] IMM_DEFAULT = IMM_I;

    localparam logic ALU1_RS  = 1'b0;
    localparam logic ALU1_PC  = 1'b1;
    localparam logic ALU2_IMM = 1'b0;
    localparam logic ALU2_RS  = 1'b1;

    localparam logic [1:0] RD_ALU  = 2'd0;
    localparam logic [1:0] RD_PCP4 = 2'd1;
    localparam logic [1:0] RD_MEM  = 2'd2;
    localparam logic [1:0] RD_IMM  = 2'd3;

    localparam logic [1:0] PC_P4  = 2'd0;
    localparam logic [1:0] PC_ALU = 2'd1;
    localparam logic [1:0] PC_OLD = 2'd2;
    localparam logic [1:0] PC_M4  = 2'd3;

    localparam logic MEM_PC  = 1'b0;
    localparam logic MEM_ALU = 1'b1;

    // comparator ops and access widths follow the func3 encoding directly
    localparam logic [2:0] EQ  = 3'd0;
    localparam logic [2:0] NE  = 3'd1;
    localparam logic [2:0] LT  = 3'd4;
    localparam logic [2:0] GE  = 3'd5;
    localparam logic [2:0] LTU = 3'd6;
    localparam logic [2:0] GEU = 3'd7;

    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;
    localparam logic [2:0] SBU = 3'd4;
    localparam logic [2:0] SHU = 3'd5;

    localparam logic [1:0] INST_MEM = 2'd0;
    localparam logic [1:0] INST_OLD = 2'd1;
    localparam logic [1:0] INST_NOP = 2'd2;

    function automatic logic is_mem_op(input logic [4:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/ctrl_fsm_decode.sv
// Combinational opcode/func3 decode of the datapath selects, independent of
// FSM state. Unknown opcodes yield the default selects with is_legal low.
module ctrl_decode
    import ctrl_fsm_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    output logic [2:0] imm_type,
    output logic       alu1_sel,
    output logic       alu2_sel,
    output logic [1:0] rd_sel,
    output logic [2:0] cmp_op,
    output logic [2:0] sel_type,
    output logic       is_legal
);

    always_comb begin
        imm_type = IMM_DEFAULT;
        alu1_sel = ALU1_RS;
        alu2_sel = ALU2_IMM;
        rd_sel   = RD_ALU;
        cmp_op   = EQ;
        sel_type = SW;
        is_legal = 1'b1;
        case (opcode)
            OPC_OP:     alu2_sel = ALU2_RS;
            OPC_OP_IMM: imm_type = IMM_I;
            OPC_LUI: begin
                imm_type = IMM_U;
                rd_sel   = RD_IMM;
            end
            OPC_JAL: begin
                imm_type = IMM_J;
                alu1_sel = ALU1_PC;
                rd_sel   = RD_PCP4;
            end
            OPC_JALR: begin
                imm_type = IMM_I;
                rd_sel   = RD_PCP4;
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                alu1_sel = ALU1_PC;
                cmp_op   = func3;
            end
            OPC_LOAD: begin
                imm_type = IMM_I;
                sel_type = func3;
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                sel_type = func3;
            end
            default: is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control FSM for the rysy RV32I core: flush/execute/memory/
// load-writeback sequencing with ack- or latency-terminated memory phases.
module ctrl_fsm
    import ctrl_fsm_pkg::*;
#(
    parameter int ACK_MODE = 1,
    parameter int MEM_LAT  = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic       b,
    input  logic       mem_ack,
    input  logic       stall,
    output logic [2:0] imm_type,
    output logic       alu1_sel,
    output logic       alu2_sel,
    output logic [1:0] rd_sel,
    output logic [1:0] pc_sel,
    output logic       mem_sel,
    output logic [2:0] cmp_op,
    output logic [2:0] sel_type,
    output logic [1:0] inst_sel,
    output logic       reg_wr,
    output logic       we,
    output logic       mem_req,
    output logic       busy,
    output logic       mem_err,
    output logic       ill_op
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mem_store, mem_store_nxt;
    logic [1:0]       dec_rd_sel;
    logic             dec_legal;
    logic             mem_done;
    logic             timeout;

    ctrl_decode u_decode (
        .opcode   (opcode),
        .func3    (func3),
        .imm_type (imm_type),
        .alu1_sel (alu1_sel),
        .alu2_sel (alu2_sel),
        .rd_sel   (dec_rd_sel),
        .cmp_op   (cmp_op),
        .sel_type (sel_type),
        .is_legal (dec_legal)
    );

    // cnt is zero on the first (S_EXEC) cycle of an access, so it counts the
    // request cycles already spent before the current one.
    assign mem_done = (ACK_MODE != 0) ? mem_ack
                    : ((MEM_LAT == 1) || (cnt == CNT_W'(MEM_LAT - 1)));
    assign timeout  = (ACK_MODE != 0) && !mem_ack && (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FLUSH;
            cnt       <= '0;
            mem_store <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_store <= mem_store_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = '0;
        mem_store_nxt = mem_store;
        case (state)
            S_FLUSH: state_nxt = S_EXEC;
            S_EXEC: begin
                if (!stall) begin
                    case (opcode)
                        OPC_JAL, OPC_JALR: state_nxt = S_FLUSH;
                        OPC_BRANCH:        if (b) state_nxt = S_FLUSH;
                        OPC_LOAD, OPC_STORE: begin
                            mem_store_nxt = (opcode == OPC_STORE);
                            if (mem_done) begin
                                state_nxt = (opcode == OPC_STORE) ? S_FLUSH : S_LOAD_WB;
                            end else begin
                                state_nxt = S_MEM;
                                cnt_nxt   = cnt + 1'b1;
                            end
                        end
                        default: state_nxt = S_EXEC;
                    endcase
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    state_nxt = mem_store ? S_FLUSH : S_LOAD_WB;
                end else if (timeout) begin
                    state_nxt = S_FLUSH;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_LOAD_WB: state_nxt = S_FLUSH;
            default:   state_nxt = S_FLUSH;
        endcase
    end

    always_comb begin
        pc_sel   = PC_P4;
        inst_sel = INST_MEM;
        mem_sel  = MEM_PC;
        rd_sel   = dec_rd_sel;
        reg_wr   = 1'b0;
        we       = 1'b0;
        mem_req  = 1'b0;
        mem_err  = 1'b0;
        ill_op   = 1'b0;
        busy     = (state != S_EXEC);
        case (state)
            S_FLUSH: inst_sel = INST_NOP;
            S_EXEC: begin
                if (stall) begin
                    pc_sel   = PC_OLD;
                    inst_sel = INST_OLD;
                end else begin
                    ill_op = !dec_legal;
                    case (opcode)
                        OPC_OP, OPC_OP_IMM, OPC_LUI: reg_wr = 1'b1;
                        OPC_JAL, OPC_JALR: begin
                            reg_wr   = 1'b1;
                            rd_sel   = RD_PCP4;
                            pc_sel   = PC_ALU;
                            inst_sel = INST_NOP;
                        end
                        OPC_BRANCH: begin
                            if (b) begin
                                pc_sel   = PC_ALU;
                                inst_sel = INST_NOP;
                            end
                        end
                        OPC_LOAD, OPC_STORE: begin
                            mem_req  = 1'b1;
                            mem_sel  = MEM_ALU;
                            pc_sel   = PC_OLD;
                            inst_sel = INST_OLD;
                            we       = (opcode == OPC_STORE);
                        end
                        default: pc_sel = PC_P4;
                    endcase
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_sel  = MEM_ALU;
                pc_sel   = PC_OLD;
                inst_sel = INST_OLD;
                we       = mem_store;
                mem_err  = timeout;
            end
            S_LOAD_WB: begin
                reg_wr   = 1'b1;
                rd_sel   = RD_MEM;
                inst_sel = INST_NOP;
            end
            default: inst_sel = INST_NOP;
        endcase
        // reset abandons any in-flight request combinationally
        if (rst) begin
            reg_wr   = 1'b0;
            we       = 1'b0;
            mem_req  = 1'b0;
            mem_err  = 1'b0;
            ill_op   = 1'b0;
            inst_sel = INST_NOP;
            pc_sel   = PC_OLD;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: an ack-terminated and a fixed-latency instance share one
// stimulus stream and are each compared against a behavioural model every cycle.
module tb_ctrl_fsm;
    import ctrl_fsm_pkg::*;

    localparam int LAT1 = 3;
    localparam int TMO  = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic       b;
    logic       mem_ack;
    logic       stall;

    logic [2:0] imm_type [2];
    logic       alu1_sel [2];
    logic       alu2_sel [2];
    logic [1:0] rd_sel   [2];
    logic [1:0] pc_sel   [2];
    logic       mem_sel  [2];
    logic [2:0] cmp_op   [2];
    logic [2:0] sel_type [2];
    logic [1:0] inst_sel [2];
    logic       reg_wr   [2];
    logic       we       [2];
    logic       mem_req  [2];
    logic       busy     [2];
    logic       mem_err  [2];
    logic       ill_op   [2];

    int n_checks = 0;
    int n_fail   = 0;

    // model: what the unit is doing, in terms of pending work
    bit m_flush [2];
    bit m_wb    [2];
    bit m_mem   [2];
    bit m_store [2];
    int m_age   [2];

    int req_cnt [2];
    int we_cnt  [2];
    int err_cnt [2];
    int ill_cnt [2];

    ctrl_fsm #(.ACK_MODE(1), .MEM_LAT(1), .TIMEOUT(TMO)) dut_ack (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .b(b),
        .mem_ack(mem_ack), .stall(stall),
        .imm_type(imm_type[0]), .alu1_sel(alu1_sel[0]), .alu2_sel(alu2_sel[0]),
        .rd_sel(rd_sel[0]), .pc_sel(pc_sel[0]), .mem_sel(mem_sel[0]),
        .cmp_op(cmp_op[0]), .sel_type(sel_type[0]), .inst_sel(inst_sel[0]),
        .reg_wr(reg_wr[0]), .we(we[0]), .mem_req(mem_req[0]), .busy(busy[0]),
        .mem_err(mem_err[0]), .ill_op(ill_op[0])
    );

    ctrl_fsm #(.ACK_MODE(0), .MEM_LAT(LAT1), .TIMEOUT(TMO)) dut_lat (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .b(b),
        .mem_ack(mem_ack), .stall(stall),
        .imm_type(imm_type[1]), .alu1_sel(alu1_sel[1]), .alu2_sel(alu2_sel[1]),
        .rd_sel(rd_sel[1]), .pc_sel(pc_sel[1]), .mem_sel(mem_sel[1]),
        .cmp_op(cmp_op[1]), .sel_type(sel_type[1]), .inst_sel(inst_sel[1]),
        .reg_wr(reg_wr[1]), .we(we[1]), .mem_req(mem_req[1]), .busy(busy[1]),
        .mem_err(mem_err[1]), .ill_op(ill_op[1])
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // {imm_type, alu1, alu2, rd, cmp, sel} expected from the core's decode table
    function automatic logic [12:0] exp_dec(input logic [4:0] op, input logic [2:0] f3);
        logic [2:0] imm;
        logic       a1, a2;
        logic [1:0] rd;
        logic [2:0] cmp, sel;
        imm = IMM_DEFAULT; a1 = ALU1_RS; a2 = ALU2_IMM; rd = RD_ALU; cmp = EQ; sel = SW;
        case (op)
            OPC_OP:     a2 = ALU2_RS;
            OPC_OP_IMM: imm = IMM_I;
            OPC_LUI:    begin imm = IMM_U; rd = RD_IMM; end
            OPC_JAL:    begin imm = IMM_J; a1 = ALU1_PC; rd = RD_PCP4; end
            OPC_JALR:   begin imm = IMM_I; rd = RD_PCP4; end
            OPC_BRANCH: begin imm = IMM_B; a1 = ALU1_PC; cmp = f3; end
            OPC_LOAD:   begin imm = IMM_I; sel = f3; end
            OPC_STORE:  begin imm = IMM_S; sel = f3; end
            default:    imm = IMM_DEFAULT;
        endcase
        return {imm, a1, a2, rd, cmp, sel};
    endfunction

    task automatic model_cycle(input int k);
        logic       e_reg_wr, e_we, e_req, e_err, e_ill, e_busy, e_msel;
        logic [1:0] e_pc, e_inst, e_rd;
        bit         chk_rd, chk_dec, n_flush, n_wb, n_mem, n_store, st, done, tmo;
        int         n_age, age;
        string      p;
        p = (k == 0) ? "ack" : "lat";
        e_reg_wr = 0; e_we = 0; e_req = 0; e_err = 0; e_ill = 0; e_busy = 0;
        e_msel = MEM_PC; e_pc = PC_P4; e_inst = INST_MEM; e_rd = RD_ALU;
        chk_rd = 0; chk_dec = 0;
        n_flush = 0; n_wb = 0; n_mem = 0; n_store = 0; n_age = 0;
        if (rst) begin
            e_pc = PC_OLD; e_inst = INST_NOP; n_flush = 1;
        end else if (m_wb[k]) begin
            e_reg_wr = 1; e_rd = RD_MEM; chk_rd = 1; e_inst = INST_NOP; e_busy = 1;
            n_flush = 1;
        end else if (m_flush[k]) begin
            e_inst = INST_NOP; e_busy = 1;
        end else if (m_mem[k] || (!stall && (opcode == OPC_LOAD || opcode == OPC_STORE))) begin
            st   = m_mem[k] ? m_store[k] : (opcode == OPC_STORE);
            age  = m_mem[k] ? m_age[k] : 0;
            done = (k == 0) ? mem_ack : (age + 1 == LAT1);
            tmo  = (k == 0) && m_mem[k] && !mem_ack && (age == TMO);
            e_req = 1; e_we = st; e_msel = MEM_ALU; e_pc = PC_OLD; e_inst = INST_OLD;
            e_busy = m_mem[k]; e_err = tmo;
            chk_dec = !m_mem[k];
            if (done) begin
                if (st) n_flush = 1; else n_wb = 1;
            end else if (tmo) begin
                n_flush = 1;
            end else begin
                n_mem = 1; n_store = st; n_age = age + 1;
            end
        end else if (stall) begin
            e_pc = PC_OLD; e_inst = INST_OLD;
        end else begin
            chk_dec = 1;
            case (opcode)
                OPC_OP, OPC_OP_IMM, OPC_LUI: e_reg_wr = 1;
                OPC_JAL, OPC_JALR: begin
                    e_reg_wr = 1; e_pc = PC_ALU; e_inst = INST_NOP; n_flush = 1;
                end
                OPC_BRANCH: if (b) begin
                    e_pc = PC_ALU; e_inst = INST_NOP; n_flush = 1;
                end
                default: e_ill = 1;
            endcase
        end
        check({p, ".reg_wr"},   reg_wr[k],   e_reg_wr);
        check({p, ".we"},       we[k],       e_we);
        check({p, ".mem_req"},  mem_req[k],  e_req);
        check({p, ".mem_err"},  mem_err[k],  e_err);
        check({p, ".ill_op"},   ill_op[k],   e_ill);
        check({p, ".pc_sel"},   pc_sel[k],   e_pc);
        check({p, ".inst_sel"}, inst_sel[k], e_inst);
        if (!rst) begin
            check({p, ".busy"},    busy[k],    e_busy);
            check({p, ".mem_sel"}, mem_sel[k], e_msel);
        end
        if (chk_rd) check({p, ".rd_sel"}, rd_sel[k], e_rd);
        if (chk_dec)
            check({p, ".decode"},
                  {imm_type[k], alu1_sel[k], alu2_sel[k], rd_sel[k], cmp_op[k], sel_type[k]},
                  exp_dec(opcode, func3));
        m_flush[k] = n_flush; m_wb[k] = n_wb; m_mem[k] = n_mem;
        m_store[k] = n_store; m_age[k] = n_age;
    endtask

    task automatic sample();
        #1;
        for (int k = 0; k < 2; k++) begin
            req_cnt[k] += int'(mem_req[k]);
            we_cnt[k]  += int'(we[k]);
            err_cnt[k] += int'(mem_err[k]);
            ill_cnt[k] += int'(ill_op[k]);
            model_cycle(k);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic clr_cnt();
        for (int k = 0; k < 2; k++) begin
            req_cnt[k] = 0; we_cnt[k] = 0; err_cnt[k] = 0; ill_cnt[k] = 0;
        end
    endtask

    initial begin
        int thr;
        int sel;
        rst = 1; opcode = OPC_OP_IMM; func3 = 3'd0; b = 0; mem_ack = 0; stall = 0;
        for (int k = 0; k < 2; k++) begin
            m_flush[k] = 0; m_wb[k] = 0; m_mem[k] = 0; m_store[k] = 0; m_age[k] = 0;
        end
        clr_cnt();
        tick();

        // reset then OP_IMM
        step(); step();
        rst = 0;
        sample();
        check("rst_flush_inst", inst_sel[0], INST_NOP);
        tick();
        sample();
        check("opimm_reg_wr", reg_wr[0], 1);
        check("opimm_pc_sel", pc_sel[0], PC_P4);
        check("opimm_busy", busy[0], 0);
        tick();

        // load acknowledged three cycles after the request
        clr_cnt();
        opcode = OPC_LOAD; func3 = SW;
        step();
        opcode = OPC_OP_IMM;
        step(); step();
        mem_ack = 1;
        step();
        mem_ack = 0;
        sample();
        check("load_wb_reg_wr", reg_wr[0], 1);
        check("load_wb_rd_sel", rd_sel[0], RD_MEM);
        tick();
        sample();
        check("load_flush_inst", inst_sel[0], INST_NOP);
        tick();
        check("load_req_cycles", req_cnt[0], 4);
        step(); step();

        // store with no ack: timeout on the ack instance, fixed latency on the other
        clr_cnt();
        opcode = OPC_STORE; func3 = SH;
        step();
        opcode = OPC_OP_IMM;
        repeat (20) step();
        check("tmo_req_cycles", req_cnt[0], 16);
        check("tmo_err_pulses", err_cnt[0], 1);
        check("lat_we_cycles", we_cnt[1], LAT1);
        check("lat_err_pulses", err_cnt[1], 0);

        // fixed latency ignores a toggling ack
        clr_cnt();
        opcode = OPC_STORE; func3 = SB;
        mem_ack = 1;
        step();
        opcode = OPC_OP_IMM;
        for (int i = 0; i < 8; i++) begin
            mem_ack = i[0];
            step();
        end
        mem_ack = 0;
        check("lat_toggle_we_cycles", we_cnt[1], LAT1);
        step(); step();

        // branch taken then not taken
        opcode = OPC_BRANCH; func3 = NE; b = 1;
        sample();
        check("br_cmp_op", cmp_op[0], NE);
        check("br_taken_pc", pc_sel[0], PC_ALU);
        check("br_taken_inst", inst_sel[0], INST_NOP);
        tick();
        b = 0;
        sample();
        check("br_flush_inst", inst_sel[0], INST_NOP);
        tick();
        sample();
        check("br_not_taken_pc", pc_sel[0], PC_P4);
        tick();
        sample();
        check("br_not_taken_busy", busy[0], 0);
        tick();

        // stalled JAL, then an illegal opcode
        opcode = OPC_JAL; stall = 1;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("stall_pc_sel", pc_sel[0], PC_OLD);
            check("stall_reg_wr", reg_wr[0], 0);
            tick();
        end
        stall = 0;
        sample();
        check("jal_reg_wr", reg_wr[0], 1);
        check("jal_pc_sel", pc_sel[0], PC_ALU);
        tick();
        clr_cnt();
        opcode = 5'b11111;
        step();
        sample();
        check("ill_reg_wr", reg_wr[0], 0);
        tick();
        opcode = OPC_OP_IMM;
        step();
        check("ill_pulses", ill_cnt[0], 1);

        // reset in the middle of a memory access
        opcode = OPC_STORE; func3 = SW;
        step();
        opcode = OPC_OP_IMM;
        step();
        rst = 1;
        sample();
        check("rst_mem_req", mem_req[0], 0);
        check("rst_we", we[0], 0);
        tick();
        rst = 0;
        step(); step();

        // random traffic
        thr = 8;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) thr = (c % 600 == 0) ? 0 : ((c % 400 == 0) ? 2 : 8);
            rst     = ($urandom_range(0, 99) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            mem_ack = ($urandom_range(0, 15) < thr);
            b       = 1'($urandom);
            func3   = 3'($urandom);
            sel     = $urandom_range(0, 10);
            case (sel)
                0: opcode = OPC_LOAD;
                1: opcode = OPC_STORE;
                2: opcode = OPC_OP;
                3: opcode = OPC_OP_IMM;
                4: opcode = OPC_LUI;
                5: opcode = OPC_BRANCH;
                6: opcode = OPC_JAL;
                7: opcode = OPC_JALR;
                default: opcode = 5'($urandom);
            endcase
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
